// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared FSM state encoding and default parameters for clk_enable_gen.
package clk_gen_pkg;
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;
    localparam int DEF_NUM_CH    = 5;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_LOCK_HOLD = 1024;
endpackage

// File: rtl/clk_gen_nco.sv
// clk_gen_nco: one phase accumulator with its increment/phase registers and a
// registered carry that forms the channel's clock-enable pulse.
module clk_gen_nco
    import clk_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    input  logic [ACC_W-1:0] wr_phase,
    input  logic             load,
    input  logic             advance,
    output logic             ce
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] phase;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // The add always uses the registered inc, so a write lands one cycle later;
    // a load coinciding with a write takes the freshly written phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            inc   <= '0;
            phase <= '0;
            ce    <= 1'b0;
        end else begin
            if (wr) begin
                inc   <= wr_inc;
                phase <= wr_phase;
            end
            if (load)
                acc <= wr ? wr_phase : phase;
            else if (advance)
                acc <= sum[ACC_W-1:0];
            ce <= advance & sum[ACC_W];
        end
    end
endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel NCO clock-enable generator gated by a
// synchronised, debounced PLL lock indication.
module clk_enable_gen
    import clk_gen_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int LOCK_HOLD = DEF_LOCK_HOLD,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic              running
);
    localparam int CNT_W = $clog2(LOCK_HOLD);

    logic             sync1;
    logic             lock;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             go_run;
    logic             advance;
    logic             load;
    logic             wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            lock      <= 1'b0;
            state     <= WAIT_LOCK;
            cnt       <= '0;
            cfg_ready <= 1'b0;
        end else begin
            sync1     <= pll_locked;
            lock      <= sync1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            cfg_ready <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go_run   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (!lock)
                    state_nx = WAIT_LOCK;
                else if (cnt == CNT_W'(LOCK_HOLD - 1)) begin
                    state_nx = RUN;
                    go_run   = 1'b1;
                end else
                    cnt_nx = cnt + 1'b1;
            end
            RUN:     state_nx = lock ? RUN : WAIT_LOCK;
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // A resync cycle loads instead of adding, which also blanks the next ce.
    assign running = (state == RUN);
    assign advance = running & lock & ~resync;
    assign load    = go_run | (running & resync);
    assign wr      = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gen_nco #(.ACC_W(ACC_W)) u_nco (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr && (cfg_ch == CH_W'(i))),
            .wr_inc   (cfg_inc),
            .wr_phase (cfg_phase),
            .load     (load),
            .advance  (advance),
            .ce       (ce[i])
        );
    end
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: scoreboard bench; expected ce/running per cycle come from
// a closed-form accumulator-crossing model queued as stimulus is driven.
module tb_clk_enable_gen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       resync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_inc = 8'd0;
    logic [7:0] cfg_phase = 8'd0;
    logic       cfg_ready, running, aux_ready, aux_running;
    logic [1:0] ce;
    logic [2:0] aux_ce;

    typedef struct {logic [1:0] ce; logic run;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;
    int k = 0;
    int a0[2];
    int incv[2];

    always #5 clk = ~clk;

    clk_enable_gen #(.NUM_CH(2), .ACC_W(8), .LOCK_HOLD(4)) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .resync(resync),
        .cfg_valid(cfg_valid && (cfg_ch < 2'd2)), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch[0]),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .ce(ce), .running(running)
    );

    // Wider instance so an out-of-range channel index is expressible.
    clk_enable_gen #(.NUM_CH(3), .ACC_W(8), .LOCK_HOLD(4)) aux (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .resync(resync),
        .cfg_valid(cfg_valid), .cfg_ready(aux_ready), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .ce(aux_ce), .running(aux_running)
    );

    function automatic logic [1:0] model_ce(int n);
        logic [1:0] r;
        for (int c = 0; c < 2; c++)
            r[c] = ((a0[c] + n * incv[c]) >> 8) != ((a0[c] + (n - 1) * incv[c]) >> 8);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg_set(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
    endtask

    task automatic cfg_clear;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cfg_ready, running, aux_ready, aux_running} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl ready/run=%b%b aux=%b%b want 0000", cfg_ready, running, aux_ready, aux_running);
        end
        checks++;
        if ({aux_ce, ce} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ce got ce=%b aux_ce=%b want 0", ce, aux_ce);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got %b want 0", cfg_ready);
        end
        tick();
        checks++;
        if ({cfg_ready, aux_ready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_after_edge got %b%b want 11", cfg_ready, aux_ready);
        end
    endtask

    task automatic test_lockup;
        for (int n = 2; n <= 7; n++) begin
            if (n == 2) cfg_set(2'd0, 8'h80, 8'h00);
            else if (n == 3) cfg_set(2'd1, 8'h40, 8'h00);
            else cfg_clear();
            q.push_back('{ce: 2'b00, run: (n == 7)});
            tick();
            e = q.pop_front();
            checks++;
            if ({aux_running, running, aux_ce, ce} !== {e.run, e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL lockup edge=%0d run=%b ce=%b aux_ce=%b want run=%b ce=%b", n, running, ce, aux_ce, e.run, e.ce);
            end
        end
        a0   = '{0, 0};
        incv = '{128, 64};
        k    = 0;
    endtask

    task automatic test_rates;
        for (int n = 0; n < 12; n++) begin
            k++;
            q.push_back('{ce: model_ce(k), run: 1'b1});
            tick();
            e = q.pop_front();
            checks++;
            if ({aux_running, running, aux_ce, ce} !== {e.run, e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL rates k=%0d run=%b ce=%b aux_ce=%b want ce=%b", k, running, ce, aux_ce, e.ce);
            end
        end
    endtask

    task automatic test_resync;
        cfg_set(2'd1, 8'h40, 8'hC0);
        resync = 1'b1;
        q.push_back('{ce: 2'b00, run: 1'b1});
        tick();
        resync = 1'b0;
        cfg_clear();
        e = q.pop_front();
        checks++;
        if ({running, aux_ce, ce} !== {e.run, 1'b0, e.ce, e.ce}) begin
            failures++;
            $display("FAIL resync_blank run=%b ce=%b aux_ce=%b want ce=%b", running, ce, aux_ce, e.ce);
        end
        a0 = '{0, 192};
        k  = 0;
        for (int n = 0; n < 10; n++) begin
            k++;
            q.push_back('{ce: model_ce(k), run: 1'b1});
            tick();
            e = q.pop_front();
            checks++;
            if ({running, aux_ce, ce} !== {e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL resync k=%0d ce=%b aux_ce=%b want ce=%b", k, ce, aux_ce, e.ce);
            end
        end
    endtask

    task automatic test_lock_loss_run;
        pll_locked = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n < 2) begin
                k++;
                q.push_back('{ce: model_ce(k), run: 1'b1});
            end else
                q.push_back('{ce: 2'b00, run: 1'b0});
            if (n == 2) cfg_set(2'd0, 8'h80, 8'h80);
            else cfg_clear();
            tick();
            e = q.pop_front();
            checks++;
            if ({aux_running, running, aux_ce, ce} !== {e.run, e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL lock_loss step=%0d run=%b ce=%b aux_ce=%b want run=%b ce=%b", n, running, ce, aux_ce, e.run, e.ce);
            end
        end
        cfg_clear();
        a0 = '{128, 192};
    endtask

    task automatic test_hold_glitch;
        for (int n = 1; n <= 11; n++) begin
            pll_locked = (n != 4);
            q.push_back('{ce: 2'b00, run: (n == 11)});
            tick();
            e = q.pop_front();
            checks++;
            if ({aux_running, running, aux_ce, ce} !== {e.run, e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL hold_glitch edge=%0d run=%b ce=%b want run=%b ce=%b", n, running, ce, e.run, e.ce);
            end
        end
        k = 0;
        for (int n = 0; n < 8; n++) begin
            k++;
            q.push_back('{ce: model_ce(k), run: 1'b1});
            tick();
            e = q.pop_front();
            checks++;
            if ({running, aux_ce, ce} !== {e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL relock k=%0d ce=%b aux_ce=%b want ce=%b", k, ce, aux_ce, e.ce);
            end
        end
    endtask

    task automatic test_cfg_update;
        for (int n = 0; n < 10; n++) begin
            if (n == 0) cfg_set(2'd0, 8'h00, 8'h80);
            else if (n == 1) cfg_set(2'd3, 8'hFF, 8'h55);
            else cfg_clear();
            k++;
            q.push_back('{ce: model_ce(k), run: 1'b1});
            if (n == 0) begin
                a0[0]   = a0[0] + k * incv[0];
                incv[0] = 0;
            end
            tick();
            e = q.pop_front();
            checks++;
            if ({running, aux_ce, ce} !== {e.run, 1'b0, e.ce, e.ce}) begin
                failures++;
                $display("FAIL cfg_update step=%0d ce=%b aux_ce=%b want ce=%b", n, ce, aux_ce, e.ce);
            end
        end
    endtask

    task automatic test_async_reset;
        while (k < 21) begin
            k++;
            q.push_back('{ce: model_ce(k), run: 1'b1});
            tick();
            e = q.pop_front();
            checks++;
            if ({running, ce} !== {e.run, e.ce}) begin
                failures++;
                $display("FAIL pre_reset k=%0d ce=%b want %b", k, ce, e.ce);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({running, aux_running, cfg_ready, ce, aux_ce} !== 8'b0) begin
            failures++;
            $display("FAIL async_reset run=%b ready=%b ce=%b aux_ce=%b want all 0", running, cfg_ready, ce, aux_ce);
        end
    endtask

    initial begin
        test_reset();
        test_lockup();
        test_rates();
        test_resync();
        test_lock_loss_run();
        test_hold_glitch();
        test_cfg_update();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter NUM_CH, default 5, SHALL set the number of clock-enable output channels (1..16).
REQ-002 Parameter ACC_W, default 32, SHALL set the phase-accumulator width per channel (8..48).
REQ-003 Parameter LOCK_HOLD, default 1024, SHALL set the cycles pll_locked must stay high before outputs run (>=2).
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 pll_locked  in  1  PLL lock flag, asynchronous to clk.
REQ-007 resync  in  1  single-cycle pulse; reload all accumulators with their phase values.
REQ-008 cfg_valid  in  1  config write request.
REQ-009 cfg_ready  out  1  config write accept.
REQ-010 cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
REQ-011 cfg_inc  in  ACC_W  frequency increment word.
REQ-012 cfg_phase  in  ACC_W  phase offset word.
REQ-013 ce  out  NUM_CH  per-channel single-cycle clock-enable pulses.
REQ-014 running  out  1  high while in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; all use is of the synchronised value.
REQ-016 FSM states: WAIT_LOCK, HOLD, RUN.
REQ-017 WAIT_LOCK -> HOLD when synced lock = 1; hold counter cleared.
REQ-018 HOLD: counter increments each cycle while lock = 1; -> RUN when counter reaches LOCK_HOLD-1; -> WAIT_LOCK on lock = 0.
REQ-019 RUN -> WAIT_LOCK on synced lock = 0, same cycle ce forced to 0.
REQ-020 On HOLD->RUN transition every accumulator SHALL load its phase register.
REQ-021 In RUN each cycle: {carry, acc} = acc + inc (ACC_W+1-bit add); ce[i] = carry, registered, 1-cycle latency.
REQ-022 Output rate per channel SHALL be inc / 2^ACC_W x f_clk; inc = 0 never pulses; wrap-around of acc is modulo 2^ACC_W.
REQ-023 Outside RUN, ce SHALL be 0 and accumulators frozen.
REQ-024 cfg_ready SHALL be 1 in all states after reset; write occurs when cfg_valid & cfg_ready.
REQ-025 A write SHALL update inc and phase registers of cfg_ch; new inc used from the next cycle's add; the cycle of the write uses the old inc.
REQ-026 A write SHALL NOT load acc; phase takes effect at the next resync or HOLD->RUN.
REQ-027 cfg_ch >= NUM_CH SHALL be accepted and ignored.
REQ-028 resync in RUN SHALL load every acc from phase that cycle and suppress ce on the following cycle; resync outside RUN ignored.
REQ-029 Simultaneous resync and cfg write to channel i SHALL load acc i with the new cfg_phase.
REQ-030 Lock loss during resync or cfg write: config write still completes; FSM goes to WAIT_LOCK.

Reset
REQ-031 reset_n low SHALL asynchronously set: state WAIT_LOCK, counter 0, synchroniser 0, all acc/inc/phase 0, ce 0, running 0, cfg_ready 0.
REQ-032 cfg_ready SHALL rise the first cycle after reset_n deasserts.
REQ-033 Reset assertion mid-RUN SHALL drop ce and running immediately (asynchronously).

Structure
REQ-034 Shared package clk_gen_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 One sub-module, clk_gen_nco (single accumulator + inc/phase registers + carry output), SHALL be instantiated NUM_CH times.

Verification (ACC_W=8, NUM_CH=2, LOCK_HOLD=4)
REQ-036 Reset, pll_locked=1 constant -> running rises 2 (sync) + 1 + 4 cycles after reset release; ce stays 0 before.
REQ-037 ch0 inc=0x80 phase=0, ch1 inc=0x40 phase=0 -> in RUN, ce[0] every 2nd cycle, ce[1] every 4th cycle.
REQ-038 ch1 phase=0xC0 then resync -> first ce[1] pulse 1 cycle after suppression window, then every 4 cycles.
REQ-039 pll_locked drops for 1 cycle in HOLD -> back to WAIT_LOCK, full 4-cycle hold repeated, no ce.
REQ-040 pll_locked drops in RUN -> ce=0 and running=0 within 3 cycles; relock resumes from phase values.
REQ-041 cfg write ch0 inc=0x00 during RUN, and a write with cfg_ch=3 -> ce[0] stops after at most one pulse; ch1 unaffected.
